// File: rtl/instr_fetch_unit.sv
// Instruction fetch: FETCH/WAIT/HOLD/HALT sequencer with a single outstanding imem read.
// Latency: instr_valid rises 2+ cycles after FETCH (memory latency >= 1); next PC resolves on retire.
// Backpressure: the held Instr/PC stay put until instr_ready; a misaligned target halts until reset.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] ImmExt,
    input  logic [31:0] ALUResult,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        misaligned
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        HOLD,
        HALT
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_q, pc_nxt;
    logic [31:0] instr_q, instr_nxt;
    logic        vld_q, vld_nxt;
    logic        mis_q, mis_nxt;
    logic [31:0] target;

    assign PC          = pc_q;
    assign PCPlus4     = pc_q + 32'd4;
    assign Instr       = instr_q;
    assign instr_valid = vld_q;
    assign misaligned  = mis_q;
    assign imem_addr   = pc_q;

    // Next-PC candidate; only consumed when the held instruction retires.
    always_comb begin
        target = PCPlus4;
        case (PCSrc)
            2'b01:   target = pc_q + ImmExt;
            2'b10:   target = {ALUResult[31:1], 1'b0};
            default: target = PCPlus4;
        endcase
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        instr_nxt = instr_q;
        vld_nxt   = vld_q;
        mis_nxt   = mis_q;
        imem_req  = 1'b0;
        case (state)
            FETCH: begin
                imem_req  = ~reset;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    instr_nxt = imem_rdata;
                    vld_nxt   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    vld_nxt = 1'b0;
                    // A misaligned target keeps the faulting PC visible for the trap path.
                    if (target[1:0] == 2'b00) begin
                        pc_nxt    = target;
                        state_nxt = FETCH;
                    end else begin
                        mis_nxt   = 1'b1;
                        state_nxt = HALT;
                    end
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            vld_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            instr_q <= instr_nxt;
            vld_q   <= vld_nxt;
            mis_q   <= mis_nxt;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run against a PC-level model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] Instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  PCSrc;
    logic [31:0] ImmExt;
    logic [31:0] ALUResult;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        misaligned;

    int vectors;
    int miscompares;

    instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk),
        .reset(reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .Instr(Instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .PCSrc(PCSrc),
        .ImmExt(ImmExt),
        .ALUResult(ALUResult),
        .PC(PC),
        .PCPlus4(PCPlus4),
        .misaligned(misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a falling edge; holds reset across one rising edge and releases it.
    task automatic reset_dut();
        @(negedge clk);
        reset       = 1'b1;
        imem_rvalid = 1'b0;
        instr_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Acts as memory and decode for one instruction: waits for the request, answers after
    // lat cycles, holds for stall cycles, then retires with the given PCSrc/ImmExt/ALUResult.
    // Stray rvalid/ready are driven where the DUT must ignore them.
    task automatic run_fetch(input int lat, input logic [31:0] data, input int stall,
                             input logic [1:0] src, input logic [31:0] imm, input logic [31:0] alu,
                             output bit found, output int wcyc, output logic [31:0] addr,
                             output logic [31:0] ins, output logic [31:0] pc_o,
                             output logic [31:0] pcp4, output logic vld, output int bad);
        found = 0; wcyc = 0; bad = 0;
        addr = '0; ins = '0; pc_o = '0; pcp4 = '0; vld = 1'b0;
        #1;
        while (!found && wcyc < 40) begin
            if (imem_req === 1'b1) begin
                found = 1;
                addr  = imem_addr;
            end else begin
                @(negedge clk); #1;
                wcyc++;
            end
        end
        if (found) begin
            imem_rvalid = 1'b1;
            imem_rdata  = ~data;
            instr_ready = 1'b1;
            for (int i = 0; i < lat; i++) begin
                @(negedge clk);
                if (imem_req !== 1'b0 || instr_valid !== 1'b0) bad++;
                imem_rvalid = (i == lat - 1);
                imem_rdata  = (i == lat - 1) ? data : $urandom;
                instr_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom;
            instr_ready = 1'b0;
            ins  = Instr;
            pc_o = PC;
            pcp4 = PCPlus4;
            vld  = instr_valid;
            if (imem_req !== 1'b0) bad++;
            repeat (stall) begin
                @(negedge clk);
                if (imem_req !== 1'b0 || Instr !== ins || PC !== pc_o || instr_valid !== vld) bad++;
                ImmExt = $urandom;
            end
            PCSrc       = src;
            ImmExt      = imm;
            ALUResult   = alu;
            instr_ready = 1'b1;
            @(negedge clk);
            instr_ready = 1'b0;
            imem_rvalid = 1'b0;
            ImmExt      = $urandom;
            ALUResult   = $urandom;
            PCSrc       = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_F00D;
        instr_ready = 1'b1;
        #1;
        vectors++;
        if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req_in_reset: got %b expected 0", imem_req); end
        @(negedge clk);
        vectors++;
        if (Instr !== NOP) begin miscompares++; $display("FAIL reset_instr: got %h expected %h", Instr, NOP); end
        vectors++;
        if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        vectors++;
        if (PC !== RST_PC) begin miscompares++; $display("FAIL reset_pc: got %h expected %h", PC, RST_PC); end
        vectors++;
        if (misaligned !== 1'b0) begin miscompares++; $display("FAIL reset_misaligned: got %b expected 0", misaligned); end
        reset       = 1'b0;
        imem_rvalid = 1'b0;
        instr_ready = 1'b0;
        #1;
        vectors++;
        if (imem_req !== 1'b1) begin miscompares++; $display("FAIL first_req: got %b expected 1", imem_req); end
        vectors++;
        if (imem_addr !== RST_PC) begin miscompares++; $display("FAIL first_addr: got %h expected %h", imem_addr, RST_PC); end
    endtask

    task automatic test_sequential();
        bit f; int w, b; logic [31:0] a, ins, pc_o, p4; logic v;
        reset_dut();
        for (int k = 0; k < 3; k++) begin
            run_fetch(1, 32'h0050_0093, 0, 2'b00, 32'h0, 32'h0, f, w, a, ins, pc_o, p4, v, b);
            vectors++;
            if (!f || w != 0) begin miscompares++; $display("FAIL seq_req_timing[%0d]: got found=%0d wait=%0d expected found=1 wait=0", k, f, w); end
            vectors++;
            if (a !== 32'(4 * k)) begin miscompares++; $display("FAIL seq_addr[%0d]: got %h expected %h", k, a, 32'(4 * k)); end
            vectors++;
            if (ins !== 32'h0050_0093 || v !== 1'b1) begin miscompares++; $display("FAIL seq_instr[%0d]: got %h/%b expected 00500093/1", k, ins, v); end
            vectors++;
            if (pc_o !== 32'(4 * k) || p4 !== 32'(4 * k + 4)) begin miscompares++; $display("FAIL seq_pc[%0d]: got %h/%h expected %h/%h", k, pc_o, p4, 32'(4 * k), 32'(4 * k + 4)); end
            vectors++;
            if (b != 0) begin miscompares++; $display("FAIL seq_protocol[%0d]: got %0d violations expected 0", k, b); end
        end
    endtask

    task automatic test_branch_jalr();
        bit f; int w, b; logic [31:0] a, ins, pc_o, p4; logic v;
        logic [1:0]  src [6] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
        logic [31:0] opa [6] = '{32'h10, 32'hFFFF_FFF8, 32'h18, 32'h101, 32'h21, 32'h102};
        logic [31:0] exp [6] = '{32'h0, 32'h10, 32'h08, 32'h20, 32'h100, 32'h20};
        reset_dut();
        for (int k = 0; k < 6; k++) begin
            run_fetch(1 + k % 3, $urandom, k % 2, src[k], opa[k], opa[k], f, w, a, ins, pc_o, p4, v, b);
            vectors++;
            if (!f || w != 0 || a !== exp[k]) begin miscompares++; $display("FAIL ctl_addr[%0d]: got found=%0d wait=%0d addr=%h expected addr=%h", k, f, w, a, exp[k]); end
            vectors++;
            if (b != 0) begin miscompares++; $display("FAIL ctl_protocol[%0d]: got %0d violations expected 0", k, b); end
            vectors++;
            if (misaligned !== (k == 5)) begin miscompares++; $display("FAIL ctl_misaligned[%0d]: got %b expected %b", k, misaligned, (k == 5)); end
        end
        vectors++;
        if (instr_valid !== 1'b0 || PC !== 32'h20) begin miscompares++; $display("FAIL halt_state: got valid=%b pc=%h expected 0/00000020", instr_valid, PC); end
        b = 0;
        for (int i = 0; i < 12; i++) begin
            if (imem_req !== 1'b0 || instr_valid !== 1'b0) b++;
            imem_rvalid = 1'($urandom_range(0, 1));
            instr_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        imem_rvalid = 1'b0;
        instr_ready = 1'b0;
        vectors++;
        if (b != 0 || misaligned !== 1'b1 || PC !== 32'h20) begin miscompares++; $display("FAIL halt_sticky: got %0d violations mis=%b pc=%h expected 0/1/00000020", b, misaligned, PC); end
    endtask

    task automatic test_stall();
        bit f; int w, b; logic [31:0] a, ins, pc_o, p4; logic v;
        reset_dut();
        run_fetch(3, 32'h1234_5678, 5, 2'b00, 32'h0, 32'h0, f, w, a, ins, pc_o, p4, v, b);
        vectors++;
        if (ins !== 32'h1234_5678 || v !== 1'b1 || pc_o !== RST_PC) begin miscompares++; $display("FAIL stall_hold: got %h/%b/%h expected 12345678/1/%h", ins, v, pc_o, RST_PC); end
        vectors++;
        if (b != 0) begin miscompares++; $display("FAIL stall_stable: got %0d violations expected 0", b); end
        run_fetch(1, 32'h0, 0, 2'b00, 32'h0, 32'h0, f, w, a, ins, pc_o, p4, v, b);
        vectors++;
        if (!f || w != 0 || a !== 32'h4) begin miscompares++; $display("FAIL stall_advance: got found=%0d wait=%0d addr=%h expected 1/0/00000004", f, w, a); end
    endtask

    task automatic test_wrap();
        bit f; int w, b; logic [31:0] a, ins, pc_o, p4; logic v;
        reset_dut();
        run_fetch(1, $urandom, 0, 2'b10, 32'h0, 32'hFFFF_FFFD, f, w, a, ins, pc_o, p4, v, b);
        run_fetch(2, $urandom, 0, 2'b00, 32'h0, 32'h0, f, w, a, ins, pc_o, p4, v, b);
        vectors++;
        if (a !== 32'hFFFF_FFFC || p4 !== 32'h0) begin miscompares++; $display("FAIL wrap_top: got addr=%h pcplus4=%h expected fffffffc/00000000", a, p4); end
        run_fetch(1, $urandom, 0, 2'b00, 32'h0, 32'h0, f, w, a, ins, pc_o, p4, v, b);
        vectors++;
        if (!f || a !== 32'h0 || misaligned !== 1'b0) begin miscompares++; $display("FAIL wrap_next: got found=%0d addr=%h mis=%b expected 1/00000000/0", f, a, misaligned); end
    endtask

    task automatic test_reset_in_wait();
        bit f; int w, b; logic [31:0] a, ins, pc_o, p4; logic v;
        reset_dut();
        run_fetch(1, $urandom, 0, 2'b01, 32'h40, 32'h0, f, w, a, ins, pc_o, p4, v, b);
        @(negedge clk);
        vectors++;
        if (PC !== 32'h40 || imem_req !== 1'b0) begin miscompares++; $display("FAIL rw_setup: got pc=%h req=%b expected 00000040/0", PC, imem_req); end
        reset       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        instr_ready = 1'b1;
        @(negedge clk);
        reset       = 1'b0;
        imem_rvalid = 1'b0;
        instr_ready = 1'b0;
        vectors++;
        if (Instr !== NOP || instr_valid !== 1'b0 || PC !== RST_PC) begin miscompares++; $display("FAIL rw_reset: got %h/%b/%h expected %h/0/%h", Instr, instr_valid, PC, NOP, RST_PC); end
        run_fetch(1, 32'hA5A5_0013, 0, 2'b00, 32'h0, 32'h0, f, w, a, ins, pc_o, p4, v, b);
        vectors++;
        if (!f || w != 0 || a !== RST_PC || ins !== 32'hA5A5_0013) begin miscompares++; $display("FAIL rw_refetch: got found=%0d wait=%0d addr=%h instr=%h expected 1/0/%h/a5a50013", f, w, a, ins, RST_PC); end
    endtask

    task automatic test_random();
        bit f; int w, b; logic [31:0] a, ins, pc_o, p4; logic v;
        logic [31:0] exp_pc, data, imm, alu, tgt;
        logic [1:0]  src;
        reset_dut();
        exp_pc = RST_PC;
        for (int n = 0; n < 80; n++) begin
            data = $urandom;
            src  = 2'($urandom_range(0, 3));
            imm  = $urandom;
            alu  = $urandom;
            if ($urandom_range(0, 7) != 0) imm = imm & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) != 0) alu = alu & 32'hFFFF_FFFD;
            if (src == 2'd1)      tgt = exp_pc + imm;
            else if (src == 2'd2) tgt = alu & 32'hFFFF_FFFE;
            else                  tgt = exp_pc + 32'd4;
            run_fetch($urandom_range(1, 4), data, $urandom_range(0, 3), src, imm, alu,
                      f, w, a, ins, pc_o, p4, v, b);
            vectors++;
            if (!f || w != 0 || a !== exp_pc) begin miscompares++; $display("FAIL rnd_addr[%0d]: got found=%0d wait=%0d addr=%h expected %h", n, f, w, a, exp_pc); end
            vectors++;
            if (ins !== data || v !== 1'b1 || pc_o !== exp_pc || p4 !== exp_pc + 32'd4) begin miscompares++; $display("FAIL rnd_hold[%0d]: got %h/%b/%h/%h expected %h/1/%h/%h", n, ins, v, pc_o, p4, data, exp_pc, exp_pc + 32'd4); end
            vectors++;
            if (b != 0) begin miscompares++; $display("FAIL rnd_protocol[%0d]: got %0d violations expected 0", n, b); end
            if (tgt % 4 != 0) begin
                vectors++;
                if (misaligned !== 1'b1 || instr_valid !== 1'b0 || PC !== exp_pc || imem_req !== 1'b0) begin miscompares++; $display("FAIL rnd_halt[%0d]: got mis=%b vld=%b pc=%h req=%b expected 1/0/%h/0", n, misaligned, instr_valid, PC, imem_req, exp_pc); end
                reset_dut();
                exp_pc = RST_PC;
            end else begin
                vectors++;
                if (misaligned !== 1'b0) begin miscompares++; $display("FAIL rnd_mis[%0d]: got %b expected 0", n, misaligned); end
                exp_pc = tgt;
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        PCSrc       = 2'b00;
        ImmExt      = 32'h0;
        ALUResult   = 32'h0;
        repeat (2) @(negedge clk);
        test_reset();
        test_sequential();
        test_branch_jalr();
        test_stall();
        test_wrap();
        test_reset_in_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
